// File: rtl/pipelined_subtractor.sv
// 128-bit unsigned subtractor, four 32-bit slices, one slice per pipeline stage.
// The borrow ripples from stage to stage. Valid/ready flow control lets bubbles collapse.
module pipelined_subtractor (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] d,
    output logic         borrow,
    output logic         zero,
    output logic         out_valid,
    input  logic         out_ready
);

    // One 32-bit slice: {bout, diff} = {0,x} - {0,y} - bin. The top bit is the borrow-out.
    function automatic logic [32:0] sub_slice(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic        bin
    );
        return {1'b0, x} - {1'b0, y} - {32'd0, bin};
    endfunction

    // Each stage keeps only the operand slices it still has to consume.
    logic         s1_valid;
    logic [95:0]  s1_a;
    logic [95:0]  s1_b;
    logic [31:0]  s1_diff;
    logic         s1_borrow;
    logic         s1_zero;

    logic         s2_valid;
    logic [63:0]  s2_a;
    logic [63:0]  s2_b;
    logic [63:0]  s2_diff;
    logic         s2_borrow;
    logic         s2_zero;

    logic         s3_valid;
    logic [31:0]  s3_a;
    logic [31:0]  s3_b;
    logic [95:0]  s3_diff;
    logic         s3_borrow;
    logic         s3_zero;

    logic         s4_valid;
    logic [127:0] s4_diff;
    logic         s4_borrow;
    logic         s4_zero;

    logic         r1;
    logic         r2;
    logic         r3;
    logic         r4;

    logic [32:0]  sl0;
    logic [32:0]  sl1;
    logic [32:0]  sl2;
    logic [32:0]  sl3;

    // An empty stage always accepts, so bubbles are squeezed out under a stall.
    assign r4       = !s4_valid || out_ready;
    assign r3       = !s3_valid || r4;
    assign r2       = !s2_valid || r3;
    assign r1       = !s1_valid || r2;
    assign in_ready = r1;

    assign sl0 = sub_slice(a[31:0],    b[31:0],    1'b0);
    assign sl1 = sub_slice(s1_a[31:0], s1_b[31:0], s1_borrow);
    assign sl2 = sub_slice(s2_a[31:0], s2_b[31:0], s2_borrow);
    assign sl3 = sub_slice(s3_a,       s3_b,       s3_borrow);

    // NOTE: sequential state uses non-blocking assignments only, so every stage
    // samples its predecessor's pre-edge value regardless of block ordering.
    // NOTE: the data fields are reset along with the valids, so d/borrow/zero
    // read 0 after reset instead of leftover values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_diff   <= '0;
            s1_borrow <= 1'b0;
            s1_zero   <= 1'b0;
        end else if (r1) begin
            s1_valid  <= in_valid;
            s1_a      <= a[127:32];
            s1_b      <= b[127:32];
            s1_diff   <= sl0[31:0];
            s1_borrow <= sl0[32];
            s1_zero   <= (sl0[31:0] == 32'd0);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid  <= 1'b0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
            s2_zero   <= 1'b0;
        end else if (r2) begin
            s2_valid  <= s1_valid;
            s2_a      <= s1_a[95:32];
            s2_b      <= s1_b[95:32];
            s2_diff   <= {sl1[31:0], s1_diff};
            s2_borrow <= sl1[32];
            s2_zero   <= s1_zero && (sl1[31:0] == 32'd0);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s3_valid  <= 1'b0;
            s3_a      <= '0;
            s3_b      <= '0;
            s3_diff   <= '0;
            s3_borrow <= 1'b0;
            s3_zero   <= 1'b0;
        end else if (r3) begin
            s3_valid  <= s2_valid;
            s3_a      <= s2_a[63:32];
            s3_b      <= s2_b[63:32];
            s3_diff   <= {sl2[31:0], s2_diff};
            s3_borrow <= sl2[32];
            s3_zero   <= s2_zero && (sl2[31:0] == 32'd0);
        end
    end

    // The last slice's borrow-out is the borrow of the whole 128-bit subtraction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s4_valid  <= 1'b0;
            s4_diff   <= '0;
            s4_borrow <= 1'b0;
            s4_zero   <= 1'b0;
        end else if (r4) begin
            s4_valid  <= s3_valid;
            s4_diff   <= {sl3[31:0], s3_diff};
            s4_borrow <= sl3[32];
            s4_zero   <= s3_zero && (sl3[31:0] == 32'd0);
        end
    end

    assign d         = s4_diff;
    assign borrow    = s4_borrow;
    assign zero      = s4_zero;
    assign out_valid = s4_valid;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor. A queue-based model computes the
// expected results with plain 128-bit arithmetic, and the bench checks order, latency and stalls.
module tb_pipelined_subtractor;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [127:0] a;
    logic [127:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] d;
    logic         borrow;
    logic         zero;
    logic         out_valid;
    logic         out_ready;

    pipelined_subtractor dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .borrow    (borrow),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic         borrow;
        logic         zero;
        int           stamp;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           strict_lat = 1'b0;
    int           pops = 0;
    int           first_pop = -1;
    int           last_pop = -1;
    bit           prev_hold = 1'b0;
    logic [127:0] prev_d;
    logic         prev_borrow;
    logic         prev_zero;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // The model works on whole 128-bit numbers and uses no slices.
    function automatic exp_t model(input logic [127:0] x, input logic [127:0] y, input int stamp);
        exp_t e;
        e.d      = x - y;
        e.borrow = (x < y);
        e.zero   = (x == y);
        e.stamp  = stamp;
        return e;
    endfunction

    // One clock cycle. The inputs are already driven at the negedge.
    // This task samples the DUT, scores the transfers that happen on the coming edge, then advances.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        if (prev_hold) begin
            check("hold_valid",  out_valid, 1);
            check("hold_d",      d,         prev_d);
            check("hold_borrow", borrow,    prev_borrow);
            check("hold_zero",   zero,      prev_zero);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("d",      d,      e.d);
                check("borrow", borrow, e.borrow);
                check("zero",   zero,   e.zero);
                if (strict_lat) check("latency", cyc - e.stamp, 4);
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back(model(a, b, cyc));
        prev_hold   = out_valid && !out_ready;
        prev_d      = d;
        prev_borrow = borrow;
        prev_zero   = zero;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // A single isolated transaction with an exact cycle-by-cycle out_valid profile.
    task automatic single(input string tag, input logic [127:0] x, input logic [127:0] y,
                          input logic [127:0] exp_d, input logic exp_b, input logic exp_z);
        bit acc;
        strict_lat = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        a          = x;
        b          = y;
        cycle(acc);
        check({tag, "_accept"}, acc, 1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_early_valid"}, out_valid, 0);
            cycle(acc);
        end
        check({tag, "_valid"},  out_valid, 1);
        check({tag, "_d"},      d,         exp_d);
        check({tag, "_borrow"}, borrow,    exp_b);
        check({tag, "_zero"},   zero,      exp_z);
        cycle(acc);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_empty"},      sb.size(), 0);
    endtask

    task automatic drain(input string tag);
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(acc);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        int           idx;
        int           n_acc;
        bit           pending;
        logic [127:0] xs[6];
        logic [127:0] ys[6];

        n_rst     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_d",         d,         0);
        check("rst_borrow",    borrow,    0);
        check("rst_zero",      zero,      0);
        check("rst_in_ready",  in_ready,  1);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        single("basic",     128'd5, 128'd3, 128'd2, 1'b0, 1'b0);
        single("underflow", 128'd0, 128'd1, {128{1'b1}}, 1'b1, 1'b0);
        single("ripple96",  128'd1 << 96, 128'd1, {32'd0, {96{1'b1}}}, 1'b0, 1'b0);
        single("ripple127", 128'd1 << 127, (128'd1 << 127) + 128'd1, {128{1'b1}}, 1'b1, 1'b0);
        single("equal",     128'hDEADBEEF_01234567_89ABCDEF_00000123,
                            128'hDEADBEEF_01234567_89ABCDEF_00000123, 128'd0, 1'b0, 1'b1);

        // Back-to-back random traffic with no stall: exact latency for every result.
        strict_lat = 1'b1;
        out_ready  = 1'b1;
        n_acc      = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a        = rnd128();
            b        = (i % 4 == 0) ? a : rnd128();
            cycle(acc);
            if (acc) n_acc++;
        end
        check("stream_accepts", n_acc, 20);
        drain("stream");

        // Backpressure: six offers while the consumer stalls.
        strict_lat = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xs[i] = rnd128();
            ys[i] = rnd128();
        end
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a        = xs[idx];
            b        = ys[idx];
            cycle(acc);
            if (acc) idx++;
        end
        check("bp_accepted",  idx,       4);
        check("bp_in_ready",  in_ready,  0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        pops      = 0;
        first_pop = -1;
        for (int i = 0; i < 20 && pops < 6; i++) begin
            if (idx < 6) begin
                in_valid = 1'b1;
                a        = xs[idx];
                b        = ys[idx];
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", idx,                      6);
        check("bp_pops",         pops,                     6);
        check("bp_no_gaps",      last_pop - first_pop + 1, 6);
        drain("bp");

        // Random valid/ready mix. An offer is held until it is taken.
        pending = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                in_valid = ($urandom_range(0, 2) != 0);
                a        = rnd128();
                b        = ($urandom_range(0, 7) == 0) ? a : rnd128();
            end
            cycle(acc);
            pending = in_valid && !acc;
        end
        drain("mix");

        // Reset while three transactions are in flight.
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = rnd128();
            b        = rnd128();
            cycle(acc);
            if (acc) n_acc++;
        end
        check("rst_mid_accepts", n_acc, 3);
        in_valid = 1'b0;
        cycle(acc);
        check("rst_mid_pre_valid", out_valid, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_d",         d,         0);
        check("rst_mid_borrow",    borrow,    0);
        check("rst_mid_in_ready",  in_ready,  1);
        sb.delete();
        prev_hold = 1'b0;
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        single("post_rst", 128'd10, 128'd4, 128'd6, 1'b0, 1'b0);

        check("final_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
